// File: rtl/mux16_scan_pkg.sv
// mux16_scan_pkg
// Shared constants, state encodings and select-range helpers for the
// 16:1 mux scan serializer and its select counter.
// The parity beat (MUX16_SCAN_PARITY_EN) uses ST_PAR; without that macro
// the encoding is simply never reached.
package mux16_scan_pkg;

  localparam int SEL_W  = 4;
  localparam int DATA_W = 16;

  // state | meaning
  // IDLE  | no word held for output, ready for a new word
  // SHIFT | presenting data beats, one mux select per beat
  // PAR   | presenting the trailing even-parity beat (parity build only)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_PAR   = 2'd2;

  function automatic logic [SEL_W-1:0] sel_start(input logic msb_first);
    return msb_first ? 4'd15 : 4'd0;
  endfunction

  function automatic logic [SEL_W-1:0] sel_end(input logic msb_first);
    return msb_first ? 4'd0 : 4'd15;
  endfunction

endpackage

// File: rtl/mux16_scan_serializer_scan_sel_counter.sv
// scan_sel_counter
// 4-bit select counter for the 16:1 mux: load to the scan start, step one
// position toward the scan end, or hold. It saturates at the end position
// so the select can never wrap back into the word.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset (sel returns to start)
//   msb_first   scan direction (0: 0->15, 1: 15->0)
//   load        reload start position (wins over step)
//   step        advance one position unless already at end
//   sel         current select
//   at_end      sel is at the final scan position
module scan_sel_counter
  import mux16_scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             msb_first,
  input  logic             load,
  input  logic             step,
  output logic [SEL_W-1:0] sel,
  output logic             at_end
);

  assign at_end = (sel == sel_end(msb_first));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel <= sel_start(msb_first);
    end else if (load) begin
      sel <= sel_start(msb_first);
    end else if (step && !at_end) begin
      sel <= msb_first ? sel - 4'd1 : sel + 4'd1;
    end
  end

endmodule

// File: rtl/mux16_scan_serializer.sv
// mux16_scan_serializer
// Loads a 16-bit word, drives it onto an external combinational 16:1 mux,
// steps the mux select, and returns the selected bit as a valid/ready
// serial stream. A new word can be taken on the last beat for zero-bubble
// streaming.
// Optional feature macro: MUX16_SCAN_PARITY_EN adds a trailing even-parity
// beat (17 beats per word, ser_last on the parity beat).
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     parallel word handshake, in_data the word
//   mux_a, mux_sel        data bus and select to the 16:1 mux
//   mux_out               selected bit back from the mux
//   ser_valid/ser_ready   serial beat handshake
//   ser_data, ser_last    serial bit, final beat of the word
//   busy                  word in flight
module mux16_scan_serializer
  import mux16_scan_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] mux_a,
  output logic [SEL_W-1:0]  mux_sel,
  input  logic              mux_out,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              ser_data,
  output logic              ser_last,
  output logic              busy
);

  logic [1:0] state;
  logic       at_end;
  logic       accept;
  logic       beat;
  logic       sel_step;

  assign ser_valid = (state != ST_IDLE);
  assign busy      = (state != ST_IDLE);

`ifdef MUX16_SCAN_PARITY_EN
  assign ser_last = (state == ST_PAR);
  assign ser_data = (state == ST_SHIFT) ? mux_out :
                    (state == ST_PAR)   ? ^mux_a  : 1'b0;
`else
  assign ser_last = (state == ST_SHIFT) && at_end;
  assign ser_data = (state == ST_SHIFT) && mux_out;
`endif

  // Taking a word on the last beat keeps the stream gap-free; rst_n gating
  // keeps upstream from seeing ready while the block is held in reset.
  assign in_ready = rst_n && ((state == ST_IDLE) || (ser_ready && ser_last));
  assign accept   = in_valid && in_ready;
  assign beat     = ser_valid && ser_ready;
  assign sel_step = (state == ST_SHIFT) && beat && !at_end;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      mux_a <= '0;
    end else if (accept) begin
      state <= ST_SHIFT;
      mux_a <= in_data;
    end else if (beat && ser_last) begin
      state <= ST_IDLE;
`ifdef MUX16_SCAN_PARITY_EN
    end else if ((state == ST_SHIFT) && beat && at_end) begin
      state <= ST_PAR;
`endif
    end
  end

  scan_sel_counter u_sel (
    .clk       (clk),
    .rst_n     (rst_n),
    .msb_first (MSB_FIRST),
    .load      (accept),
    .step      (sel_step),
    .sel       (mux_sel),
    .at_end    (at_end)
  );

endmodule

// File: doc/mux16_scan_serializer.md
Name: mux16_scan_serializer

Overview:
- Parallel-to-serial scanner that drives the team's 16:1 bit multiplexer. It loads a 16-bit word, presents it on the mux data bus and steps the 4-bit select.
- It returns the selected mux output as a valid/ready serial bit stream.
- Sits directly upstream of the 16:1 mux (drives its data and select) and consumes its single-bit output. The mux itself stays external and combinational.

Parameters:
- MSB_FIRST, 0, 0: scan select 0→15 (LSB first); 1: scan 15→0.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  parallel word valid
- in_ready  output  1  block can accept a word this cycle
- in_data  input  16  parallel word
- mux_a  output  16  data bus to 16:1 mux
- mux_sel  output  4  select to 16:1 mux
- mux_out  input  1  selected bit returned from mux (combinational path)
- ser_valid  output  1  serial bit valid
- ser_ready  input  1  downstream accepts serial bit
- ser_data  output  1  serial bit
- ser_last  output  1  final beat of current word
- busy  output  1  word in flight

Behaviour:
- One clock (clk). Reset is synchronous and active-low (rst_n); it is sampled only on the rising edge of clk.
- Reset values:
  - state=IDLE, mux_a=16'h0000.
  - mux_sel=START (0, or 15 when MSB_FIRST=1).
  - ser_valid=0, ser_last=0, busy=0, ser_data=0.
  - in_ready=0 while rst_n=0.
- START=0/END=15 when MSB_FIRST=0; START=15/END=0 otherwise. STEP is +1 or −1 respectively.
- States: IDLE, SHIFT (plus PAR under PARITY_EN).
- IDLE:
  - in_ready=1, ser_valid=0.
  - On in_valid&&in_ready: mux_a<=in_data, mux_sel<=START, state<=SHIFT.
- SHIFT:
  - ser_valid=1, busy=1.
  - ser_data=mux_out (combinational pass-through). Because it is combinational, any change on mux_out propagates to ser_data in the same cycle.
  - ser_last=(mux_sel==END).
- Beat handshake: a beat completes on a rising edge with ser_valid&&ser_ready.
  - Not last: mux_sel<=mux_sel+STEP.
  - Last: state<=IDLE, unless a new word is accepted in the same cycle.
- Back-to-back: in_ready is also 1 in SHIFT when ser_ready&&ser_last. On in_valid in that cycle, load the new word, set mux_sel<=START and stay in SHIFT. This gives zero bubble: 16 beats per word sustained.
- Latency: word accepted at edge N → first ser_valid in cycle N+1. The minimum word occupies 16 cycles.
- Backpressure: while ser_valid&&!ser_ready, mux_a, mux_sel and ser_last hold stable. ser_data stays stable provided the mux is stable.
- mux_a is never modified during SHIFT. In IDLE it retains the last word.
- in_valid while busy and not on the last accepted beat is ignored. Upstream must hold in_valid (standard valid/ready).
- Reset mid-word: the word is discarded and all outputs return to reset values on that edge. No ser_last is emitted for a partial word.
- mux_sel wrap never occurs: the counter stops at END. Verification must flag mux_sel stepping past END.

Optional Feature:
- Macro: MUX16_SCAN_PARITY_EN.
- Defined:
  - After the END beat handshakes, enter PAR for one beat: ser_valid=1, ser_data=^mux_a (even parity), ser_last=1.
  - ser_last is 0 on the END data beat. mux_sel holds END during PAR.
  - Back-to-back accept moves to the PAR beat. A word occupies 17 beats.
- Undefined: PAR state and parity logic are absent; behaviour is exactly as above.

Decomposition:
- Shared package mux16_scan_pkg:
  - state enum (IDLE, SHIFT, PAR)
  - SEL_W=4 and DATA_W=16 constants
  - sel_start(msb_first) / sel_end(msb_first) functions
- One natural sub-module: scan_sel_counter.
  - 4-bit load/step/hold counter with direction input.
  - Outputs sel and at_end.
  - Synchronous active-low reset.
- The bench instantiates the existing 16:1 mux between mux_a/mux_sel and mux_out.

Test Plan:
1. rst_n low 2 cycles, then high → in_ready=1, ser_valid=0, mux_sel=0, mux_a=0 (MSB_FIRST=0).
2. in_data=16'hA5C3, ser_ready=1, MSB_FIRST=0 → ser_data over 16 consecutive cycles = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1. ser_last only on beat 16.
3. Two words 16'hFFFF then 16'h0000 with in_valid held, ser_ready=1 → 32 contiguous ser_valid cycles: 16 ones, then 16 zeros. in_ready pulses on beat 16.
4. 16'hA5C3, ser_ready low for 3 cycles at beat 5 → mux_sel holds 4, ser_data holds 0. The sequence resumes unchanged; total 19 cycles.
5. rst_n low during beat 8 → next cycle ser_valid=0, mux_sel=0, no ser_last. A following word of 16'h8001 streams 1, fourteen 0s, 1.
6. MUX16_SCAN_PARITY_EN, MSB_FIRST=1:
   - 16'h0001 → bits 0×15, 1, then parity beat 1 with ser_last.
   - 16'hA5C3 → parity beat 0.
